// File: rtl/int2flt_pipe_if.sv
// Valid/ready bus for int2flt_pipe: integer samples in, packed floats out.
// The slave modport is the converter's view; the master modport is the producer/consumer view.
interface int2flt_pipe_if #(
    parameter int MAG_W  = 7,
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [MAG_W:0]          in_data;
    logic                    tc_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+FRAC_W:0]   out_flt;
    logic                    out_inexact;

    modport master (
        output in_valid, in_data, tc_mode, out_ready,
        input  in_ready, out_valid, out_flt, out_inexact
    );

    modport slave (
        input  in_valid, in_data, tc_mode, out_ready,
        output in_ready, out_valid, out_flt, out_inexact
    );
endinterface

// File: rtl/int2flt_pipe.sv
// Three-stage integer-to-float converter (sign/magnitude, leading-one detect, normalise/pack).
// Define INT2FLT_ROUND_EN to round-to-nearest-even in stage 3; otherwise the fraction is truncated.
module int2flt_pipe #(
    parameter int MAG_W  = 7,
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    int2flt_pipe_if.slave bus
);
    generate
        if ((2 ** EXP_W) - 1 < MAG_W + 1 || MAG_W < 1 || FRAC_W < 1) begin : g_bad_params
            $error("int2flt_pipe: need MAG_W>=1, FRAC_W>=1 and 2^EXP_W-1 >= MAG_W+1");
        end
    endgenerate

    logic                  s1_valid;
    logic                  s1_sign;
    logic [MAG_W:0]        s1_mag;
    logic                  s2_valid;
    logic                  s2_sign;
    logic [MAG_W:0]        s2_mag;
    logic [EXP_W-1:0]      s2_exp;
    logic                  out_valid_q;
    logic [EXP_W+FRAC_W:0] out_flt_q;
    logic                  out_inexact_q;

    logic s1_en;
    logic s2_en;
    logic s3_en;

    // A stage loads when it is empty or its contents move on this cycle.
    assign s3_en = !out_valid_q || bus.out_ready;
    assign s2_en = !s2_valid || s3_en;
    assign s1_en = !s1_valid || s2_en;

    assign bus.in_ready    = s1_en;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_flt     = out_flt_q;
    assign bus.out_inexact = out_inexact_q;

    logic           sign_d;
    logic [MAG_W:0] mag_d;

    // The most negative two's-complement input negates onto itself, which is exactly 2^MAG_W.
    always_comb begin
        sign_d = bus.in_data[MAG_W];
        if (bus.tc_mode) begin
            mag_d = sign_d ? (~bus.in_data + {{MAG_W{1'b0}}, 1'b1}) : bus.in_data;
        end else begin
            mag_d = {1'b0, bus.in_data[MAG_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
        end else if (s1_en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign <= sign_d;
                s1_mag  <= mag_d;
            end
        end
    end

    logic [EXP_W-1:0] lod_exp;

    always_comb begin
        lod_exp = '0;
        for (int i = 0; i <= MAG_W; i++) begin
            if (s1_mag[i]) begin
                lod_exp = EXP_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_mag   <= '0;
            s2_exp   <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_mag  <= s1_mag;
                s2_exp  <= lod_exp;
            end
        end
    end

    logic [EXP_W-1:0]      shamt;
    logic [MAG_W:0]        norm;
    logic [MAG_W+FRAC_W:0] ext;
    logic [FRAC_W-1:0]     frac;
    logic [EXP_W-1:0]      exp_o;
    logic                  inexact;
`ifdef INT2FLT_ROUND_EN
    logic                  round_up;
    logic                  carry;
    logic [FRAC_W-1:0]     frac_r;
`endif

    // ext appends FRAC_W zeros so the fraction slice is well defined even when FRAC_W > MAG_W+1;
    // everything below the fraction (ext[MAG_W:0]) is the discarded part.
    always_comb begin
        shamt   = EXP_W'(MAG_W + 1) - s2_exp;
        norm    = s2_mag << shamt;
        ext     = {norm, {FRAC_W{1'b0}}};
        frac    = ext[MAG_W+FRAC_W -: FRAC_W];
        inexact = |ext[MAG_W:0];
        exp_o   = s2_exp;
`ifdef INT2FLT_ROUND_EN
        round_up        = ext[MAG_W] && ((|ext[MAG_W-1:0]) || frac[0]);
        {carry, frac_r} = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
        frac            = frac_r;
        if (carry) begin
            frac[FRAC_W-1] = 1'b1;
            exp_o          = s2_exp + EXP_W'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_flt_q     <= '0;
            out_inexact_q <= 1'b0;
        end else if (s3_en) begin
            out_valid_q <= s2_valid;
            if (s2_valid) begin
                out_flt_q     <= {s2_sign, exp_o, frac};
                out_inexact_q <= inexact;
            end
        end
    end
endmodule

// File: tb/tb_int2flt_pipe.sv
// Random and directed bench for int2flt_pipe: a default instance and a FRAC_W=4 instance share one input stream.
// Expected results come from an arithmetic reference model and an in-order scoreboard.
module tb_int2flt_pipe;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       tc_mode;
    logic       out_ready;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit lat_mode = 1'b0;
    bit last_acc;
    bit last_emit;

    bit         next_chk_a = 1'b0;
    logic [12:0] next_dir_a = '0;
    bit         next_chk_b = 1'b0;
    logic [8:0] next_dir_b = '0;
    logic       next_dir_bx = 1'b0;

`ifdef INT2FLT_ROUND_EN
    localparam logic [8:0] B_7F = 9'b0_1000_1000;
`else
    localparam logic [8:0] B_7F = 9'b0_0111_1111;
`endif

    typedef struct {
        logic [12:0] fa;
        logic        xa;
        logic [8:0]  fb;
        logic        xb;
        int          acc;
        bit          chk_a;
        logic [12:0] dir_a;
        bit          chk_b;
        logic [8:0]  dir_b;
        logic        dir_bx;
    } exp_t;

    exp_t sb[$];

    int2flt_pipe_if #(.MAG_W(7), .EXP_W(4), .FRAC_W(8)) ia ();
    int2flt_pipe_if #(.MAG_W(7), .EXP_W(4), .FRAC_W(4)) ib ();

    assign ia.in_valid  = in_valid;
    assign ia.in_data   = in_data;
    assign ia.tc_mode   = tc_mode;
    assign ia.out_ready = out_ready;
    assign ib.in_valid  = in_valid;
    assign ib.in_data   = in_data;
    assign ib.tc_mode   = tc_mode;
    assign ib.out_ready = out_ready;

    int2flt_pipe #(.MAG_W(7), .EXP_W(4), .FRAC_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    int2flt_pipe #(.MAG_W(7), .EXP_W(4), .FRAC_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    // Value-level model: find the exponent as the bit length of |x|, keep the top fw bits.
    function automatic void model(input logic [7:0] d, input bit tc, input int fw,
                                  output logic [63:0] flt, output logic inx);
        int sign, m, e, frac, drop, rem;
        sign = d[7] ? 1 : 0;
        if (tc) m = sign ? 256 - int'(d) : int'(d);
        else    m = int'(d) % 128;
        e = 0;
        while ((1 << e) <= m) e++;
        inx  = 1'b0;
        frac = 0;
        if (m != 0) begin
            if (fw >= e) begin
                frac = m << (fw - e);
            end else begin
                drop = e - fw;
                frac = m >> drop;
                rem  = m - (frac << drop);
                inx  = (rem != 0);
`ifdef INT2FLT_ROUND_EN
                if (2 * rem > (1 << drop) || (2 * rem == (1 << drop) && frac % 2 == 1)) frac++;
                if (frac == (1 << fw)) begin
                    frac = frac >> 1;
                    e++;
                end
`endif
            end
        end
        flt = 64'((longint'(sign) << (4 + fw)) | (longint'(e) << fw) | longint'(frac));
    endfunction

    task automatic cycle();
        exp_t        ent;
        logic [63:0] fa, fb;
        logic        xa, xb;
        #1;
        last_acc  = in_valid && ia.in_ready;
        last_emit = ia.out_valid && out_ready;
        checkOutput("in_ready_a", ia.in_ready, (sb.size() < 3) || out_ready);
        checkOutput("in_ready_b", ib.in_ready, (sb.size() < 3) || out_ready);
        if (ia.out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_out", 1, 0);
            end else begin
                ent = sb[0];
                checkOutput("flt_a", ia.out_flt, ent.fa);
                checkOutput("inexact_a", ia.out_inexact, ent.xa);
                checkOutput("valid_b", ib.out_valid, 1);
                checkOutput("flt_b", ib.out_flt, ent.fb);
                checkOutput("inexact_b", ib.out_inexact, ent.xb);
            end
        end else if (sb.size() == 0) begin
            checkOutput("idle_valid_b", ib.out_valid, 0);
        end
        if (last_emit && sb.size() > 0) begin
            ent = sb.pop_front();
            if (lat_mode) checkOutput("latency", cyc - ent.acc, 3);
            if (ent.chk_a) checkOutput("directed_a", ia.out_flt, ent.dir_a);
            if (ent.chk_b) begin
                checkOutput("directed_b", ib.out_flt, ent.dir_b);
                checkOutput("directed_bx", ib.out_inexact, ent.dir_bx);
            end
        end
        if (last_acc) begin
            model(in_data, tc_mode, 8, fa, xa);
            model(in_data, tc_mode, 4, fb, xb);
            ent.fa = fa[12:0];  ent.xa = xa;
            ent.fb = fb[8:0];   ent.xb = xb;
            ent.acc = cyc;
            ent.chk_a = next_chk_a; ent.dir_a = next_dir_a;
            ent.chk_b = next_chk_b; ent.dir_b = next_dir_b; ent.dir_bx = next_dir_bx;
            sb.push_back(ent);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input bit tc,
                                 input bit ca, input logic [12:0] da,
                                 input bit cb, input logic [8:0] db, input logic dbx);
        in_valid = 1'b1;
        in_data  = d;
        tc_mode  = tc;
        next_chk_a = ca; next_dir_a = da;
        next_chk_b = cb; next_dir_b = db; next_dir_bx = dbx;
        cycle();
        in_valid   = 1'b0;
        next_chk_a = 1'b0;
        next_chk_b = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 50 && sb.size() > 0; k++) cycle();
        checkOutput("drain_left", sb.size(), 0);
    endtask

    initial begin
        logic [7:0] arr [6];
        int idx, acc_at, emits;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; tc_mode = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("rst_out_valid", ia.out_valid, 0);
        checkOutput("rst_out_flt", ia.out_flt, 0);
        checkOutput("rst_out_inexact", ia.out_inexact, 0);
        checkOutput("rst_in_ready", ia.in_ready, 1);
        checkOutput("rst_out_valid_b", ib.out_valid, 0);

        lat_mode = 1'b1;
        applyStimulus(8'h40, 0, 1, 13'b0_0111_10000000, 0, '0, 0);
        applyStimulus(8'h05, 0, 1, 13'b0_0011_10100000, 0, '0, 0);
        applyStimulus(8'h80, 0, 1, 13'b1_0000_00000000, 0, '0, 0);
        applyStimulus(8'h80, 1, 1, 13'b1_1000_10000000, 0, '0, 0);
        applyStimulus(8'hFB, 1, 1, 13'b1_0011_10100000, 0, '0, 0);
        applyStimulus(8'h00, 1, 1, 13'b0_0000_00000000, 0, '0, 0);
        applyStimulus(8'h5B, 0, 0, '0, 1, 9'b0_0111_1011, 1);
        applyStimulus(8'h7F, 0, 0, '0, 1, B_7F, 1);
        drain();

        for (int k = 0; k < 200; k++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = 8'($urandom_range(0, 255));
            tc_mode  = 1'($urandom_range(0, 1));
            cycle();
        end
        drain();

        lat_mode = 1'b0;
        for (int i = 0; i < 6; i++) arr[i] = 8'($urandom_range(0, 255));
        idx = 0; acc_at = -1; emits = 0;
        for (int k = 0; k < 40 && (idx < 6 || sb.size() > 0); k++) begin
            in_valid  = (idx < 6);
            in_data   = (idx < 6) ? arr[idx] : 8'h00;
            tc_mode   = idx[0];
            out_ready = (k >= 5);
            cycle();
            if (last_acc) idx++;
            if (k == 4) acc_at = idx;
            if (last_emit && k >= 5 && k <= 10) emits++;
        end
        checkOutput("bp_accepted_held", acc_at, 3);
        checkOutput("bp_emits_after_release", emits, 6);
        drain();

        for (int k = 0; k < 300; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom_range(0, 255));
            tc_mode   = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        drain();

        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(1, 255));
            tc_mode  = 1'($urandom_range(0, 1));
            cycle();
        end
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        #1;
        checkOutput("midrst_out_valid", ia.out_valid, 0);
        checkOutput("midrst_out_flt", ia.out_flt, 0);
        checkOutput("midrst_in_ready", ia.in_ready, 1);
        checkOutput("midrst_out_valid_b", ib.out_valid, 0);
        out_ready = 1'b1;
        repeat (10) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
